// File: rtl/exu_bjp_resolve_pkg.sv
// Shared widths and FSM encoding for the EXU branch/jump resolution slice.
package exu_bjp_resolve_pkg;

   localparam int PC_SIZE = 32;
   localparam int XLEN    = 32;
   localparam int CNT_W   = 32;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } bjp_state_e;

   // Sequential step for compressed vs. full-width instructions.
   function automatic logic [PC_SIZE-1:0] seq_step(input logic rvc);
      return rvc ? PC_SIZE'(2) : PC_SIZE'(4);
   endfunction

endpackage

// File: rtl/exu_bjp_cnt.sv
// Wrap-around event counter with enable; rolls from all-ones to zero.
module exu_bjp_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   assign cnt_d = cnt_q + W'(1);
   assign cnt   = cnt_q;

   exu_bjp_dffr #(.W(W)) u_cnt_ff (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (cnt_d),
      .q   (cnt_q)
   );

endmodule

// File: rtl/exu_bjp_dffr.sv
// Generic enable flop cell, asynchronous active-high reset to a parameter value.
module exu_bjp_dffr #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/exu_bjp_resolve.sv
// Resolves B/J outcomes against the IFU static prediction, raises a held redirect
// on a conditional-branch mispredict, and counts branches/mispredicts.
module exu_bjp_resolve
   import exu_bjp_resolve_pkg::*;
#(
   parameter int PC_SIZE = exu_bjp_resolve_pkg::PC_SIZE,
   parameter int XLEN    = exu_bjp_resolve_pkg::XLEN,
   parameter int CNT_W   = exu_bjp_resolve_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [PC_SIZE-1:0] i_pc,
   input  logic               i_rvc,
   input  logic               i_jal,
   input  logic               i_jalr,
   input  logic               i_bxx,
   input  logic [XLEN-1:0]    i_imm,
   input  logic [XLEN-1:0]    i_rs1,
   input  logic               i_cmp_res,
   input  logic               i_prdt_taken,
   output logic               flush_req,
   output logic [PC_SIZE-1:0] flush_pc,
   input  logic               flush_ack,
   output logic               o_cmt_valid,
   output logic               o_cmt_mis,
   output logic [CNT_W-1:0]   cnt_bjp,
   output logic [CNT_W-1:0]   cnt_mis
);

   bjp_state_e         state_d, state_q;
   logic               cmt_valid_d, cmt_valid_q;
   logic               cmt_mis_d, cmt_mis_q;
   logic               accept, taken, mis, flush_pc_en;
   logic [PC_SIZE-1:0] br_tgt, jalr_tgt, seq_pc, target, redir_pc;
   logic [XLEN-1:0]    jalr_sum;

   assign i_ready = (state_q == IDLE);
   assign accept  = i_valid & i_ready;
   assign taken   = i_jal | i_jalr | (i_bxx & i_cmp_res);
   // Only conditional branches can mispredict; JAL/JALR are resolved exactly in the IFU.
   assign mis     = i_bxx & (taken != i_prdt_taken);

   assign br_tgt   = i_pc + i_imm[PC_SIZE-1:0];
   assign jalr_sum = i_rs1 + i_imm;
   assign jalr_tgt = jalr_sum[PC_SIZE-1:0] & ~PC_SIZE'(1);
   assign seq_pc   = i_pc + seq_step(i_rvc);
   assign target   = i_jalr ? jalr_tgt : br_tgt;
   assign redir_pc = taken ? target : seq_pc;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cmt_valid_d = accept;
      cmt_mis_d   = accept & mis;
      unique case (state_q)
         IDLE: if (accept && mis) state_d = PEND;
         PEND: if (flush_ack)     state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmt_valid_q <= 1'b0;
         cmt_mis_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmt_valid_q <= cmt_valid_d;
         cmt_mis_q   <= cmt_mis_d;
      end
   end

   assign flush_req   = (state_q == PEND);
   assign o_cmt_valid = cmt_valid_q;
   assign o_cmt_mis   = cmt_mis_q;

   // Redirect target only loads on entry to PEND, so it stays stable until acked.
   assign flush_pc_en = accept & mis;

   exu_bjp_dffr #(.W(PC_SIZE)) u_flush_pc_ff (
      .clk (clk),
      .rst (rst),
      .en  (flush_pc_en),
      .d   (redir_pc),
      .q   (flush_pc)
   );

   exu_bjp_cnt #(.W(CNT_W)) u_cnt_bjp (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .cnt (cnt_bjp)
   );

   exu_bjp_cnt #(.W(CNT_W)) u_cnt_mis (
      .clk (clk),
      .rst (rst),
      .en  (flush_pc_en),
      .cnt (cnt_mis)
   );

   a_onehot_kind: assert property (@(posedge clk) disable iff (rst)
      i_valid |-> $onehot({i_jal, i_jalr, i_bxx}));

endmodule
